// File: rtl/envelope_shaper.sv
// ADSR amplitude envelope: steps a 16-bit level at a fixed tick rate and
// scales the incoming 8-bit sample by the level's upper byte.
module envelope_shaper #(
    parameter int unsigned TICK_DIV      = 100000,
    parameter logic [15:0] ATTACK_STEP   = 16'h0100,
    parameter logic [15:0] DECAY_STEP    = 16'h0080,
    parameter logic [7:0]  SUSTAIN_LEVEL = 8'hA0,
    parameter logic [15:0] RELEASE_STEP  = 16'h0040
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       gate,
    input  logic [7:0] value_in,
    output logic [7:0] value_out,
    output logic [7:0] env_level,
    output logic       busy
);

    localparam int unsigned    CNT_W          = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TICK_LAST    = CNT_W'(TICK_DIV - 1);
    localparam logic [15:0]    SUSTAIN_TARGET = {SUSTAIN_LEVEL, 8'h00};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      level_q, level_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             gate_meta_q, gate_meta_d;
    logic             gate_sync_q, gate_sync_d;
    logic             gate_prev_q, gate_prev_d;
    logic [7:0]       value_out_q, value_out_d;
    logic [7:0]       env_level_q, env_level_d;
    logic             busy_q, busy_d;

    logic             tick;
    logic             gate_rise;
    logic             gate_fall;
    logic [16:0]      attack_sum;
    logic [16:0]      decay_diff;
    logic [8:0]       gain_p1;
    logic [16:0]      product;

    // Gate synchroniser and free-running tick counter.
    always_comb begin
        gate_meta_d = gate;
        gate_sync_d = gate_meta_q;
        gate_prev_d = gate_sync_q;
        gate_rise   = gate_sync_q & ~gate_prev_q;
        gate_fall   = ~gate_sync_q & gate_prev_q;
        tick        = (tick_cnt_q == TICK_LAST);
        tick_cnt_d  = tick ? '0 : tick_cnt_q + CNT_W'(1);
    end

    // Envelope state machine; gate edges take priority over a tick step.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        attack_sum = {1'b0, level_q} + {1'b0, ATTACK_STEP};
        decay_diff = {1'b0, level_q} - {1'b0, DECAY_STEP};

        if (gate_rise) begin
            state_d = ATTACK;
        end else if (gate_fall) begin
            if (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN) begin
                state_d = RELEASE;
            end
        end else if (tick) begin
            case (state_q)
                ATTACK: begin
                    if (attack_sum >= 17'h0FFFF) begin
                        level_d = 16'hFFFF;
                        state_d = DECAY;
                    end else begin
                        level_d = attack_sum[15:0];
                    end
                end
                DECAY: begin
                    // Negative difference means the step overshot zero; clamp as well.
                    if (decay_diff[16] || (decay_diff[15:0] <= SUSTAIN_TARGET)) begin
                        level_d = SUSTAIN_TARGET;
                        state_d = SUSTAIN;
                    end else begin
                        level_d = decay_diff[15:0];
                    end
                end
                SUSTAIN: begin
                    level_d = level_q;
                end
                RELEASE: begin
                    if (level_q <= RELEASE_STEP) begin
                        level_d = '0;
                        state_d = IDLE;
                    end else begin
                        level_d = level_q - RELEASE_STEP;
                    end
                end
                IDLE: begin
                    level_d = '0;
                end
                default: begin
                    level_d = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output scaling uses g+1 so that full level passes the sample unchanged.
    always_comb begin
        gain_p1     = {1'b0, level_q[15:8]} + 9'd1;
        product     = {9'd0, value_in} * {8'd0, gain_p1};
        value_out_d = (level_q == 16'd0) ? 8'd0 : product[15:8];
        env_level_d = level_d[15:8];
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            level_q     <= '0;
            tick_cnt_q  <= '0;
            gate_meta_q <= 1'b0;
            gate_sync_q <= 1'b0;
            gate_prev_q <= 1'b0;
            value_out_q <= '0;
            env_level_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            tick_cnt_q  <= tick_cnt_d;
            gate_meta_q <= gate_meta_d;
            gate_sync_q <= gate_sync_d;
            gate_prev_q <= gate_prev_d;
            value_out_q <= value_out_d;
            env_level_q <= env_level_d;
            busy_q      <= busy_d;
        end
    end

    assign value_out = value_out_q;
    assign env_level = env_level_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_envelope_shaper.sv
// Self-checking bench for envelope_shaper: directed ADSR scenarios plus random
// gate/sample traffic, all compared against a behavioural envelope model.
module tb_envelope_shaper;

    localparam int TD  = 4;
    localparam int AS  = 'h4000;
    localparam int DS  = 'h2000;
    localparam int SUS = 'h80;
    localparam int RS  = 'h3000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       gate;
    logic [7:0] value_in;
    logic [7:0] value_out;
    logic [7:0] env_level;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    bit rand_vin = 1'b0;

    envelope_shaper #(
        .TICK_DIV     (TD),
        .ATTACK_STEP  (16'h4000),
        .DECAY_STEP   (16'h2000),
        .SUSTAIN_LEVEL(8'h80),
        .RELEASE_STEP (16'h3000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gate     (gate),
        .value_in (value_in),
        .value_out(value_out),
        .env_level(env_level),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Behavioural envelope: pin history delayed by the synchroniser depth,
    // tick derived from the edge count since reset, level kept as an int.
    typedef enum {M_IDLE, M_ATTACK, M_DECAY, M_SUSTAIN, M_RELEASE} m_state_t;
    m_state_t m_state = M_IDLE;
    int m_level = 0;
    int m_vout  = 0;
    int m_env   = 0;
    bit m_busy  = 1'b0;
    int m_cyc   = 0;
    bit pin_hist [3] = '{1'b0, 1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin : model
        bit rise;
        bit fall;
        bit tk;
        if (!rst_n) begin
            m_state  = M_IDLE;
            m_level  = 0;
            m_vout   = 0;
            m_env    = 0;
            m_busy   = 1'b0;
            m_cyc    = 0;
            pin_hist = '{1'b0, 1'b0, 1'b0};
        end else begin
            rise  = pin_hist[1] && !pin_hist[2];
            fall  = !pin_hist[1] && pin_hist[2];
            tk    = (m_cyc % TD) == TD - 1;
            m_cyc = m_cyc + 1;
            m_vout = (m_level == 0) ? 0 : (int'(value_in) * ((m_level / 256) + 1)) / 256;
            if (rise) begin
                m_state = M_ATTACK;
            end else if (fall) begin
                if (m_state == M_ATTACK || m_state == M_DECAY || m_state == M_SUSTAIN)
                    m_state = M_RELEASE;
            end else if (tk) begin
                if (m_state == M_ATTACK) begin
                    if (m_level + AS >= 'hFFFF) begin
                        m_level = 'hFFFF;
                        m_state = M_DECAY;
                    end else begin
                        m_level = m_level + AS;
                    end
                end else if (m_state == M_DECAY) begin
                    if (m_level - DS <= SUS * 256) begin
                        m_level = SUS * 256;
                        m_state = M_SUSTAIN;
                    end else begin
                        m_level = m_level - DS;
                    end
                end else if (m_state == M_RELEASE) begin
                    if (m_level <= RS) begin
                        m_level = 0;
                        m_state = M_IDLE;
                    end else begin
                        m_level = m_level - RS;
                    end
                end
            end
            pin_hist[2] = pin_hist[1];
            pin_hist[1] = pin_hist[0];
            pin_hist[0] = gate;
            m_env  = m_level / 256;
            m_busy = (m_state != M_IDLE);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rand_vin) value_in = 8'($urandom);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        gate     = 1'b0;
        value_in = 8'd200;
        rand_vin = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({value_out, env_level, busy} !== 17'h0) begin
            failures++;
            $display("[TB] FAIL reset_state got out=%0d env=%02h busy=%0b want 0/00/0", value_out, env_level, busy);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cycle();
            checks++;
            if (value_out !== 8'd0 || env_level !== 8'd0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL idle_hold cyc=%0d got out=%0d env=%02h busy=%0b want 0/00/0", i, value_out, env_level, busy);
            end
        end
    endtask

    task automatic test_attack();
        int seq[$];
        int exp_seq[4];
        int prev_env;
        int ff_seen;
        exp_seq  = '{'h40, 'h80, 'hC0, 'hFF};
        gate     = 1'b1;
        value_in = 8'd200;
        repeat (2) cycle();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_early got %0b want 0", busy);
        end
        cycle();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy_on got %0b want 1", busy);
        end
        prev_env = env_level;
        ff_seen  = 0;
        for (int i = 0; i < 40 && ff_seen < 3; i++) begin
            cycle();
            checks++;
            if (value_out !== 8'(m_vout) || env_level !== 8'(m_env) || busy !== m_busy) begin
                failures++;
                $display("[TB] FAIL attack_model got out=%0d env=%02h busy=%0b want out=%0d env=%02h busy=%0b",
                         value_out, env_level, busy, m_vout, m_env, m_busy);
            end
            if (env_level == 8'h80 && prev_env == 'h80) begin
                checks++;
                if (value_out !== 8'd100) begin
                    failures++;
                    $display("[TB] FAIL scale_half got %0d want 100", value_out);
                end
            end
            if (env_level == 8'hFF && prev_env == 'hFF) begin
                ff_seen++;
                checks++;
                if (value_out !== 8'd200) begin
                    failures++;
                    $display("[TB] FAIL scale_full got %0d want 200", value_out);
                end
            end
            if (int'(env_level) != prev_env) seq.push_back(int'(env_level));
            prev_env = env_level;
        end
        checks++;
        if (seq.size() != 4 || seq[0] != exp_seq[0] || seq[1] != exp_seq[1] ||
            seq[2] != exp_seq[2] || seq[3] != exp_seq[3]) begin
            failures++;
            $display("[TB] FAIL attack_seq got %p want %p", seq, exp_seq);
        end
    endtask

    task automatic test_decay();
        int seq[$];
        int exp_seq[4];
        int prev_env;
        exp_seq  = '{'hDF, 'hBF, 'h9F, 'h80};
        rand_vin = 1'b1;
        prev_env = env_level;
        for (int i = 0; i < 60 && !(seq.size() > 0 && seq[$] == 'h80); i++) begin
            cycle();
            checks++;
            if (value_out !== 8'(m_vout) || env_level !== 8'(m_env) || busy !== m_busy) begin
                failures++;
                $display("[TB] FAIL decay_model got out=%0d env=%02h busy=%0b want out=%0d env=%02h busy=%0b",
                         value_out, env_level, busy, m_vout, m_env, m_busy);
            end
            if (int'(env_level) != prev_env) seq.push_back(int'(env_level));
            prev_env = env_level;
        end
        checks++;
        if (seq.size() != 4 || seq[0] != exp_seq[0] || seq[1] != exp_seq[1] ||
            seq[2] != exp_seq[2] || seq[3] != exp_seq[3]) begin
            failures++;
            $display("[TB] FAIL decay_seq got %p want %p", seq, exp_seq);
        end
        for (int i = 0; i < 50 * TD; i++) begin
            cycle();
            checks++;
            if (env_level !== 8'h80 || busy !== 1'b1 || value_out !== 8'(m_vout)) begin
                failures++;
                $display("[TB] FAIL sustain_hold got env=%02h busy=%0b out=%0d want env=80 busy=1 out=%0d",
                         env_level, busy, value_out, m_vout);
            end
        end
    endtask

    task automatic test_release();
        int seq[$];
        int exp_seq[3];
        int prev_env;
        exp_seq  = '{'h50, 'h20, 'h00};
        gate     = 1'b0;
        prev_env = env_level;
        for (int i = 0; i < 40 && busy !== 1'b0; i++) begin
            cycle();
            checks++;
            if (value_out !== 8'(m_vout) || env_level !== 8'(m_env) || busy !== m_busy) begin
                failures++;
                $display("[TB] FAIL release_model got out=%0d env=%02h busy=%0b want out=%0d env=%02h busy=%0b",
                         value_out, env_level, busy, m_vout, m_env, m_busy);
            end
            if (int'(env_level) != prev_env) seq.push_back(int'(env_level));
            prev_env = env_level;
        end
        checks++;
        if (seq.size() != 3 || seq[0] != exp_seq[0] || seq[1] != exp_seq[1] || seq[2] != exp_seq[2]) begin
            failures++;
            $display("[TB] FAIL release_seq got %p want %p", seq, exp_seq);
        end
        cycle();
        checks++;
        if (value_out !== 8'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL release_idle got out=%0d busy=%0b want 0/0", value_out, busy);
        end
    endtask

    task automatic test_back_to_back();
        bit reached;
        int lvl_a;
        int exp_env;
        gate    = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 80 && !reached; i++) begin
            cycle();
            if (m_state == M_SUSTAIN) reached = 1'b1;
        end
        gate    = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            cycle();
            if (env_level == 8'h50) reached = 1'b1;
        end
        checks++;
        if (!reached) begin
            failures++;
            $display("[TB] FAIL release_5000_timeout got env=%02h want 50", env_level);
        end
        gate = 1'b1;
        repeat (3) cycle();
        checks++;
        if (env_level !== 8'h50 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL retrig_keep got env=%02h busy=%0b want env=50 busy=1", env_level, busy);
        end
        cycle();
        checks++;
        if (env_level !== 8'h90) begin
            failures++;
            $display("[TB] FAIL retrig_step got env=%02h want 90", env_level);
        end

        // Tie-break: make the synchronised rising edge land on a tick cycle.
        gate = 1'b0;
        repeat (4) cycle();
        for (int i = 0; i < 8 && (m_cyc % TD) != 1; i++) cycle();
        gate = 1'b1;
        repeat (2) cycle();
        lvl_a = int'(env_level);
        cycle();
        checks++;
        if (int'(env_level) != lvl_a || env_level !== 8'(m_env)) begin
            failures++;
            $display("[TB] FAIL tiebreak_no_step got env=%02h want %02h", env_level, lvl_a);
        end
        repeat (4) cycle();
        exp_env = (lvl_a + 'h40 > 'hFF) ? 'hFF : lvl_a + 'h40;
        checks++;
        if (int'(env_level) != exp_env) begin
            failures++;
            $display("[TB] FAIL tiebreak_next_tick got env=%02h want %02h", env_level, exp_env);
        end
    endtask

    task automatic test_async_reset();
        bit reached;
        rand_vin = 1'b0;
        rst_n    = 1'b0;
        gate     = 1'b0;
        cycle();
        rst_n    = 1'b1;
        gate     = 1'b1;
        value_in = 8'd200;
        reached  = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            cycle();
            if (env_level == 8'h80) reached = 1'b1;
        end
        cycle();
        checks++;
        if (!reached || value_out !== 8'd100) begin
            failures++;
            $display("[TB] FAIL pre_reset_level got env=%02h out=%0d want env=80 out=100", env_level, value_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (value_out !== 8'd0 || env_level !== 8'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_clear got out=%0d env=%02h busy=%0b want 0/00/0", value_out, env_level, busy);
        end
        gate = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3 * TD; i++) begin
            cycle();
            checks++;
            if (value_out !== 8'd0 || env_level !== 8'd0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL post_reset_idle got out=%0d env=%02h busy=%0b want 0/00/0", value_out, env_level, busy);
            end
        end
    endtask

    task automatic test_random_gate();
        int hold;
        rand_vin = 1'b1;
        hold     = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                gate = ~gate;
                hold = $urandom_range(40, 2);
            end
            hold--;
            cycle();
            checks++;
            if (value_out !== 8'(m_vout) || env_level !== 8'(m_env) || busy !== m_busy) begin
                failures++;
                $display("[TB] FAIL random_model cyc=%0d got out=%0d env=%02h busy=%0b want out=%0d env=%02h busy=%0b",
                         i, value_out, env_level, busy, m_vout, m_env, m_busy);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        gate     = 1'b0;
        value_in = 8'd0;
        test_reset();
        test_attack();
        test_decay();
        test_release();
        test_back_to_back();
        test_async_reset();
        test_random_gate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
